// File: rtl/alu_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_wb_stage: 2-entry in-order write-back buffer between ALU and regfile.   |
// | Optional ALU_WB_FWD_EN builds the pending-write forwarding lookup. Rev 1.0  |
// +----------------------------------------------------------------------------+
module alu_wb_stage #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          ICLK,
  input  logic          IRSTn,
  input  logic          IValid,
  output logic          OReady,
  input  logic [DW-1:0] IALUD,
  input  logic          IFgn,
  input  logic          IFgz,
  input  logic [AW-1:0] IRd,
  input  logic          IWrEn,
  input  logic          IFlagEn,
  input  logic          IRfReady,
  output logic          ORfWe,
  output logic [AW-1:0] ORfAddr,
  output logic [DW-1:0] ORfData,
  output logic          OFlagN,
  output logic          OFlagZ,
  input  logic [AW-1:0] IFwdAddr,
  output logic          OFwdHit,
  output logic [DW-1:0] OFwdData
);

  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_full  = 2'd2;

  logic [1:0][DW-1:0] r_data;
  logic [1:0][AW-1:0] r_rd;
  logic [1:0]         r_n;
  logic [1:0]         r_z;
  logic [1:0]         r_wren;
  logic [1:0]         r_flagen;
  logic [1:0]         r_count;
  logic               r_head;
  logic               r_tail;
  logic               r_flagn;
  logic               r_flagz;

  logic w_ready;
  logic w_push;
  logic w_retire;

  assign w_ready  = (r_count != c_full);
  assign w_push   = IValid && w_ready;
  // Non-writing entries never wait on the register file.
  assign w_retire = (r_count != c_empty) && (IRfReady || !r_wren[r_head]);

  always_ff @(posedge ICLK) begin
    if (!IRSTn) begin
      r_count <= c_empty;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_flagn <= 1'b0;
      r_flagz <= 1'b0;
    end else begin
      if (w_push) begin
        r_data[r_tail]   <= IALUD;
        r_rd[r_tail]     <= IRd;
        r_n[r_tail]      <= IFgn;
        r_z[r_tail]      <= IFgz;
        r_wren[r_tail]   <= IWrEn;
        r_flagen[r_tail] <= IFlagEn;
        r_tail           <= ~r_tail;
      end
      if (w_retire) begin
        r_head <= ~r_head;
        if (r_flagen[r_head]) begin
          r_flagn <= r_n[r_head];
          r_flagz <= r_z[r_head];
        end
      end
      if (w_push && !w_retire) begin
        r_count <= r_count + 2'd1;
      end else if (w_retire && !w_push) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign OReady  = w_ready;
  assign ORfWe   = (r_count != c_empty) && r_wren[r_head];
  assign ORfAddr = (r_count != c_empty) ? r_rd[r_head]   : '0;
  assign ORfData = (r_count != c_empty) ? r_data[r_head] : '0;
  assign OFlagN  = r_flagn;
  assign OFlagZ  = r_flagz;

`ifdef ALU_WB_FWD_EN
  logic w_young;
  logic w_old_hit;
  logic w_young_hit;

  // With two entries buffered, the one opposite the head is the younger.
  assign w_young     = ~r_head;
  assign w_old_hit   = (r_count != c_empty) && r_wren[r_head] && (r_rd[r_head] == IFwdAddr);
  assign w_young_hit = (r_count == c_full) && r_wren[w_young] && (r_rd[w_young] == IFwdAddr);
  assign OFwdHit     = w_old_hit || w_young_hit;
  assign OFwdData    = w_young_hit ? r_data[w_young] :
                       w_old_hit   ? r_data[r_head]  : '0;
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^IFwdAddr;
  assign OFwdHit      = 1'b0;
  assign OFwdData     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// Bench for alu_wb_stage: directed vector table, reset/forwarding sequences,
// and random traffic against a queue-based reference model.
module tb_alu_wb_stage;

  logic       clk = 1'b0;
  logic       rstn, valid, n, z, we, fe, rr;
  logic [7:0] d;
  logic [2:0] rd, fwdaddr;
  logic       ready, rfwe, fn, fz, fwdhit;
  logic [2:0] rfaddr;
  logic [7:0] rfdata, fwddata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_wb_stage #(.DW(8), .AW(3)) dut (
    .ICLK(clk), .IRSTn(rstn), .IValid(valid), .OReady(ready),
    .IALUD(d), .IFgn(n), .IFgz(z), .IRd(rd), .IWrEn(we), .IFlagEn(fe),
    .IRfReady(rr), .ORfWe(rfwe), .ORfAddr(rfaddr), .ORfData(rfdata),
    .OFlagN(fn), .OFlagZ(fz), .IFwdAddr(fwdaddr), .OFwdHit(fwdhit),
    .OFwdData(fwddata)
  );

  // Reference model: an ordered list of pending results plus the flag pair.
  typedef struct {
    logic [7:0] d;
    logic       n, z;
    logic [2:0] rd;
    logic       we, fe;
  } ent_t;
  ent_t q[$];
  logic mfn = 1'b0, mfz = 1'b0;

  task automatic model_edge();
    int  sz;
    bit  ret;
    ent_t e;
    if (!rstn) begin
      q.delete();
      mfn = 1'b0;
      mfz = 1'b0;
    end else begin
      sz  = q.size();
      ret = (sz > 0) && (rr || !q[0].we);
      if (ret) begin
        if (q[0].fe) begin
          mfn = q[0].n;
          mfz = q[0].z;
        end
        void'(q.pop_front());
      end
      if (valid && sz < 2) begin
        e.d = d; e.n = n; e.z = z; e.rd = rd; e.we = we; e.fe = fe;
        q.push_back(e);
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tag);
    bit         hit = 1'b0;
    logic [7:0] fd  = 8'h0;
    chk({tag, "_ready"}, ready, q.size() < 2);
    chk({tag, "_we"}, rfwe, (q.size() > 0) ? q[0].we : 1'b0);
    chk({tag, "_addr"}, rfaddr, (q.size() > 0) ? q[0].rd : 3'd0);
    chk({tag, "_data"}, rfdata, (q.size() > 0) ? q[0].d : 8'd0);
    chk({tag, "_fn"}, fn, mfn);
    chk({tag, "_fz"}, fz, mfz);
`ifdef ALU_WB_FWD_EN
    for (int i = 0; i < q.size(); i++)
      if (q[i].we && q[i].rd == fwdaddr) begin
        hit = 1'b1;
        fd  = q[i].d;
      end
`endif
    chk({tag, "_fwdhit"}, fwdhit, hit);
    chk({tag, "_fwddata"}, fwddata, fd);
  endtask

  // Inputs are set by the caller; checks happen at negedge, model follows the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(logic v, logic [7:0] dd, logic nn, logic zz, logic [2:0] r,
                       logic w, logic f, logic rdy);
    valid = v; d = dd; n = nn; z = zz; rd = r; we = w; fe = f; rr = rdy;
  endtask

  typedef struct {
    logic       v;  logic [7:0] d;  logic n, z;  logic [2:0] rd;
    logic       we, fe, rr;
    logic       e_rdy, e_we;  logic [2:0] e_addr;  logic [7:0] e_data;
    logic       e_fn, e_fz;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] dd, logic nn, logic zz, logic [2:0] r,
                              logic w, logic f, logic rdy, logic erdy, logic ewe,
                              logic [2:0] ea, logic [7:0] ed, logic efn, logic efz);
    vec_t t;
    t.v = v; t.d = dd; t.n = nn; t.z = zz; t.rd = r; t.we = w; t.fe = f; t.rr = rdy;
    t.e_rdy = erdy; t.e_we = ewe; t.e_addr = ea; t.e_data = ed; t.e_fn = efn; t.e_fz = efz;
    return t;
  endfunction

  initial begin
    logic       exp_hit;
    logic [7:0] exp_fd;

    // Single write
    tbl.push_back(mk(1, 8'd4,   0, 0, 3'd1, 1, 1, 1,   1, 0, 3'd0, 8'd0,   0, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 1,   1, 1, 3'd1, 8'd4,   0, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 1,   1, 0, 3'd0, 8'd0,   0, 0));
    // Stall fill, ignored third push, drain
    tbl.push_back(mk(1, 8'd8,   0, 0, 3'd2, 1, 1, 0,   1, 0, 3'd0, 8'd0,   0, 0));
    tbl.push_back(mk(1, 8'd255, 1, 0, 3'd3, 1, 1, 0,   1, 1, 3'd2, 8'd8,   0, 0));
    tbl.push_back(mk(1, 8'd66,  0, 1, 3'd4, 1, 1, 0,   0, 1, 3'd2, 8'd8,   0, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 1,   0, 1, 3'd2, 8'd8,   0, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 1,   1, 1, 3'd3, 8'd255, 0, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 0,   1, 0, 3'd0, 8'd0,   1, 0));
    // Non-writing entry retires despite a stalled register file
    tbl.push_back(mk(1, 8'd0,   0, 1, 3'd6, 0, 1, 0,   1, 0, 3'd0, 8'd0,   1, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 0,   1, 0, 3'd6, 8'd0,   1, 0));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 0,   1, 0, 3'd0, 8'd0,   0, 1));
    // Back-to-back stream 1..5, flag updates disabled
    tbl.push_back(mk(1, 8'd1,   1, 0, 3'd1, 1, 0, 1,   1, 0, 3'd0, 8'd0,   0, 1));
    tbl.push_back(mk(1, 8'd2,   1, 0, 3'd2, 1, 0, 1,   1, 1, 3'd1, 8'd1,   0, 1));
    tbl.push_back(mk(1, 8'd3,   1, 0, 3'd3, 1, 0, 1,   1, 1, 3'd2, 8'd2,   0, 1));
    tbl.push_back(mk(1, 8'd4,   1, 0, 3'd4, 1, 0, 1,   1, 1, 3'd3, 8'd3,   0, 1));
    tbl.push_back(mk(1, 8'd5,   1, 0, 3'd5, 1, 0, 1,   1, 1, 3'd4, 8'd4,   0, 1));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 1,   1, 1, 3'd5, 8'd5,   0, 1));
    tbl.push_back(mk(0, 8'd0,   0, 0, 3'd0, 0, 0, 1,   1, 0, 3'd0, 8'd0,   0, 1));

    rstn = 1'b0;
    fwdaddr = 3'd7;
    drive(0, 8'd0, 0, 0, 3'd0, 0, 0, 0);
    #1;
    step();
    step();
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].n, tbl[i].z, tbl[i].rd, tbl[i].we, tbl[i].fe, tbl[i].rr);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_we", i), rfwe, tbl[i].e_we);
      chk($sformatf("tbl%0d_addr", i), rfaddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), rfdata, tbl[i].e_data);
      chk($sformatf("tbl%0d_fn", i), fn, tbl[i].e_fn);
      chk($sformatf("tbl%0d_fz", i), fz, tbl[i].e_fz);
      chk($sformatf("tbl%0d_fwdhit", i), fwdhit, 1'b0);
      step();
    end

    // Mid-operation reset with two writes pending
    drive(1, 8'h11, 1, 1, 3'd1, 1, 1, 0); step();
    drive(1, 8'h22, 1, 1, 3'd2, 1, 1, 0); step();
    drive(0, 8'h00, 0, 0, 3'd0, 0, 0, 1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_we", rfwe, 1'b0);
    chk("rst_fn", fn, 1'b0);
    chk("rst_fz", fz, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("rst_nowrite%0d", i), rfwe, 1'b0);
    end
    step();

    // Forwarding: two pending writes to R5, younger must win
    drive(1, 8'd7, 0, 0, 3'd5, 1, 0, 0); step();
    drive(1, 8'd9, 0, 0, 3'd5, 1, 0, 0); step();
    drive(0, 8'd0, 0, 0, 3'd0, 0, 0, 0);
    fwdaddr = 3'd5;
`ifdef ALU_WB_FWD_EN
    exp_hit = 1'b1; exp_fd = 8'd9;
`else
    exp_hit = 1'b0; exp_fd = 8'd0;
`endif
    @(negedge clk);
    chk("fwd_hit5", fwdhit, exp_hit);
    chk("fwd_data5", fwddata, exp_fd);
    fwdaddr = 3'd4;
    #1;
    chk("fwd_hit4", fwdhit, 1'b0);
    step();
    rr = 1'b1;
    step();
    @(negedge clk);
    fwdaddr = 3'd5;
    #1;
    chk("fwd_hit_after_retire", fwdhit, exp_hit);
    chk("fwd_data_after_retire", fwddata, exp_hit ? 8'd9 : 8'd0);
    step();
    step();

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rstn    = ($urandom_range(0, 99) >= 2);
      valid   = ($urandom_range(0, 99) < 70);
      d       = 8'($urandom);
      n       = 1'($urandom);
      z       = 1'($urandom);
      rd      = 3'($urandom);
      we      = ($urandom_range(0, 99) < 75);
      fe      = 1'($urandom);
      rr      = ($urandom_range(0, 99) < 55);
      fwdaddr = 3'($urandom);
      @(negedge clk);
      chk_model($sformatf("rnd%0d", i));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
